// File: rtl/drv_ad56xx_multi.sv
// Serialises a multi-channel sample set into 24-bit AD56xx frames, lowest enabled channel first.
// Accept-to-SYNC-fall is one dacSclk period; inReady is low from accept until the last frame ends.
module drv_ad56xx_multi #(
   parameter int                NUM_CH        = 4,
   parameter int                DATA_WIDTH    = 16,
   parameter logic [NUM_CH-1:0] SIGN_MASK     = '0,
   parameter int                SCLK_DIVIDER  = 2,
   parameter int                SYNC_DURATION = 2,
   parameter int                UPDATE_MODE   = 0
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         inValid,
   output logic                         inReady,
   input  logic [NUM_CH*DATA_WIDTH-1:0] inData,
   input  logic [NUM_CH-1:0]            chEnable,
   output logic                         busy,
   output logic                         frameDone,
   output logic                         dacSync,
   output logic                         dacSclk,
   output logic                         dacDin
);

   generate
      if (SCLK_DIVIDER < 2 || (SCLK_DIVIDER % 2) != 0) begin : g_bad_div
         $error("SCLK_DIVIDER must be even and at least 2");
      end
      if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
         $error("NUM_CH must be in 1..8");
      end
      if (DATA_WIDTH != 12 && DATA_WIDTH != 14 && DATA_WIDTH != 16) begin : g_bad_dw
         $error("DATA_WIDTH must be 12, 14 or 16");
      end
      if (SYNC_DURATION < 1) begin : g_bad_sync
         $error("SYNC_DURATION must be at least 1");
      end
   endgenerate

   localparam int DCW = $clog2(SCLK_DIVIDER);
   localparam int GCW = $clog2(SYNC_DURATION + 1);
   localparam logic [DCW-1:0] DIV_LAST = DCW'(SCLK_DIVIDER - 1);
   localparam logic [DCW-1:0] HALF     = DCW'(SCLK_DIVIDER / 2);
   localparam logic [GCW-1:0] GAP_LAST = GCW'(SYNC_DURATION - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

   state_t                        r_state;
   logic                          r_ready;
   logic                          r_busy;
   logic                          r_fd;
   logic                          r_sync;
   logic                          r_sclk;
   logic                          r_din;
   logic [DCW-1:0]                r_divCnt;
   logic [GCW-1:0]                r_gapCnt;
   logic [4:0]                    r_bitCnt;
   logic [22:0]                   r_shift;
   logic [NUM_CH*DATA_WIDTH-1:0]  r_data;
   logic [NUM_CH-1:0]             r_remain;

   logic                          w_tick;
   logic [DCW-1:0]                w_divNext;
   logic [2:0]                    w_idx;
   logic [DATA_WIDTH-1:0]         w_sample;
   logic                          w_sign;
   logic [NUM_CH-1:0]             w_rest;
   logic [15:0]                   w_d;
   logic [2:0]                    w_cmd;
   logic [23:0]                   w_frame;
   logic                          w_start;

   assign w_tick    = (r_divCnt == DIV_LAST);
   assign w_divNext = w_tick ? '0 : r_divCnt + DCW'(1);

   // Descending scan so the lowest pending channel wins.
   always_comb begin
      w_idx    = '0;
      w_sample = '0;
      w_sign   = 1'b0;
      w_rest   = r_remain;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (r_remain[i]) begin
            w_idx     = 3'(i);
            w_sample  = r_data[i*DATA_WIDTH +: DATA_WIDTH];
            w_sign    = SIGN_MASK[i];
            w_rest    = r_remain;
            w_rest[i] = 1'b0;
         end
      end
   end

   // Left-justify into 16 bits; flipping the MSB turns two's complement into offset binary.
   always_comb begin
      w_d     = 16'(w_sample) << (16 - DATA_WIDTH);
      w_d[15] = w_d[15] ^ w_sign;
      if (UPDATE_MODE == 0)
         w_cmd = 3'b011;
      else if (w_rest == '0)
         w_cmd = 3'b010;
      else
         w_cmd = 3'b000;
      w_frame = {2'b00, w_cmd, w_idx, w_d};
   end

   assign w_start = w_tick && ((r_state == S_LOAD && r_remain != '0) ||
                               (r_state == S_GAP && r_gapCnt == GAP_LAST));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state  <= S_IDLE;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
         r_fd     <= 1'b0;
         r_sync   <= 1'b1;
         r_sclk   <= 1'b1;
         r_din    <= 1'b0;
         r_divCnt <= '0;
         r_gapCnt <= '0;
         r_bitCnt <= '0;
         r_shift  <= '0;
         r_data   <= '0;
         r_remain <= '0;
      end else begin
         r_fd <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_divCnt <= '0;
               if (r_ready && inValid) begin
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_data   <= inData;
                  r_remain <= chEnable;
                  r_state  <= S_LOAD;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            S_LOAD: begin
               r_divCnt <= w_divNext;
               if (r_remain == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end
            end
            S_SHIFT: begin
               r_divCnt <= w_divNext;
               r_sclk   <= (w_divNext < HALF);
               if (w_tick) begin
                  if (r_bitCnt == 5'd23) begin
                     r_sync   <= 1'b1;
                     r_sclk   <= 1'b1;
                     r_din    <= 1'b0;
                     r_fd     <= 1'b1;
                     r_gapCnt <= '0;
                     if (r_remain != '0) begin
                        r_state <= S_GAP;
                     end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                     end
                  end else begin
                     r_bitCnt <= r_bitCnt + 5'd1;
                     r_shift  <= {r_shift[21:0], 1'b0};
                     r_din    <= r_shift[22];
                  end
               end
            end
            S_GAP: begin
               r_divCnt <= w_divNext;
               if (w_tick)
                  r_gapCnt <= r_gapCnt + GCW'(1);
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_start) begin
            r_state  <= S_SHIFT;
            r_shift  <= w_frame[22:0];
            r_din    <= w_frame[23];
            r_sync   <= 1'b0;
            r_sclk   <= 1'b1;
            r_bitCnt <= '0;
            r_remain <= w_rest;
         end
      end
   end

   assign inReady   = r_ready;
   assign busy      = r_busy;
   assign frameDone = r_fd;
   assign dacSync   = r_sync;
   assign dacSclk   = r_sclk;
   assign dacDin    = r_din;

endmodule

// File: tb/tb_drv_ad56xx_multi.sv
// Directed bench: instance A (16-bit, DIV 2, per-channel update), instance B (12-bit signed ch0, DIV 4, joint update).
// Each instance has a falling-edge DAC model that captures frames and their bit counts.
module tb_drv_ad56xx_multi;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetN;
   logic        valid [2];
   logic        ready [2];
   logic        busy  [2];
   logic        fd    [2];
   logic        sync  [2];
   logic        sclk  [2];
   logic        din   [2];
   logic [3:0]  en    [2];
   logic [63:0] data_a;
   logic [47:0] data_b;

   int n_chk  = 0;
   int n_fail = 0;

   drv_ad56xx_multi #(
      .NUM_CH(4), .DATA_WIDTH(16), .SIGN_MASK(4'b0000),
      .SCLK_DIVIDER(2), .SYNC_DURATION(2), .UPDATE_MODE(0)
   ) u_a (
      .clk(clk), .resetN(resetN), .inValid(valid[0]), .inReady(ready[0]),
      .inData(data_a), .chEnable(en[0]), .busy(busy[0]), .frameDone(fd[0]),
      .dacSync(sync[0]), .dacSclk(sclk[0]), .dacDin(din[0])
   );

   drv_ad56xx_multi #(
      .NUM_CH(4), .DATA_WIDTH(12), .SIGN_MASK(4'b0001),
      .SCLK_DIVIDER(4), .SYNC_DURATION(1), .UPDATE_MODE(1)
   ) u_b (
      .clk(clk), .resetN(resetN), .inValid(valid[1]), .inReady(ready[1]),
      .inData(data_b), .chEnable(en[1]), .busy(busy[1]), .frameDone(fd[1]),
      .dacSync(sync[1]), .dacSclk(sclk[1]), .dacDin(din[1])
   );

   // DAC models: frame word is {bit count, 24 captured bits}.
   logic [23:0] sh0 = '0, sh1 = '0;
   int          bc0 = 0, bc1 = 0;
   logic [31:0] fq0 [$];
   logic [31:0] fq1 [$];
   int          viol0 = 0, viol1 = 0;
   logic        pd0 = 1'b0, pd1 = 1'b0;

   always @(negedge sclk[0]) if (!sync[0]) begin sh0 <= {sh0[22:0], din[0]}; bc0 <= bc0 + 1; end
   always @(negedge sclk[1]) if (!sync[1]) begin sh1 <= {sh1[22:0], din[1]}; bc1 <= bc1 + 1; end
   always @(negedge sync[0]) bc0 <= 0;
   always @(negedge sync[1]) bc1 <= 0;
   always @(posedge sync[0]) fq0.push_back({bc0[7:0], sh0});
   always @(posedge sync[1]) fq1.push_back({bc1[7:0], sh1});

   // dacDin may only move while dacSclk is high.
   always @(negedge clk) begin
      pd0 <= din[0];
      pd1 <= din[1];
      if (resetN && din[0] !== pd0 && sclk[0] !== 1'b1) viol0 <= viol0 + 1;
      if (resetN && din[1] !== pd1 && sclk[1] !== 1'b1) viol1 <= viol1 + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int k, input logic [63:0] d, input logic [3:0] m);
      @(negedge clk);
      if (k == 0) data_a = d; else data_b = d[47:0];
      en[k]    = m;
      valid[k] = 1'b1;
      @(negedge clk);
      valid[k] = 1'b0;
   endtask

   task automatic run_to_idle(input int k, output int nfd, output int nfall, output int low1,
                              output int gap1, output logic endok, output logic tmo);
      int   tfall, trise;
      logic ps;
      nfd = 0; nfall = 0; low1 = 0; gap1 = 0; endok = 1'b0; tmo = 1'b1;
      tfall = 0; trise = -1; ps = sync[k];
      for (int t = 1; t <= 5000; t++) begin
         @(negedge clk);
         if (fd[k]) nfd++;
         if (ps && !sync[k]) begin
            nfall++;
            if (nfall == 1) tfall = t;
            else if (nfall == 2) gap1 = t - trise;
         end
         if (!ps && sync[k] && trise < 0) begin
            trise = t;
            low1  = t - tfall;
         end
         ps = sync[k];
         if (!busy[k]) begin
            endok = ready[k] && fd[k] && sync[k];
            tmo   = 1'b0;
            break;
         end
      end
   endtask

   initial begin
      int   nfd, nfall, low1, gap1, slow;
      logic endok, tmo, ps, found;

      resetN = 1'b0;
      valid[0] = 1'b0; valid[1] = 1'b0;
      en[0] = '0; en[1] = '0;
      data_a = '0; data_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_sync", sync[0], 1);
      chk("rst_sclk", sclk[0], 1);
      chk("rst_din", din[0], 0);
      chk("rst_busy", busy[0], 0);
      chk("rst_fd", fd[0], 0);
      chk("rst_ready", ready[0], 0);
      resetN = 1'b1;
      @(negedge clk);
      chk("a_ready_after_rst", ready[0], 1);
      chk("b_ready_after_rst", ready[1], 1);
      fq0.delete();
      fq1.delete();

      // All four channels, per-channel update command.
      send(0, {16'h0F0F, 16'h8001, 16'hABCD, 16'h1234}, 4'hF);
      chk("a_ready_low_after_accept", ready[0], 0);
      chk("a_busy_after_accept", busy[0], 1);
      run_to_idle(0, nfd, nfall, low1, gap1, endok, tmo);
      chk("a_all_timeout", tmo, 0);
      chk("a_all_frame_done", nfd, 4);
      chk("a_all_sync_falls", nfall, 4);
      chk("a_all_sync_low_clks", low1, 48);
      chk("a_all_gap_clks", gap1, 4);
      chk("a_all_end_ready_fd", endok, 1);
      chk("a_all_nframes", fq0.size(), 4);
      chk("a_f0", fq0.pop_front(), {8'd24, 24'h181234});
      chk("a_f1", fq0.pop_front(), {8'd24, 24'h19ABCD});
      chk("a_f2", fq0.pop_front(), {8'd24, 24'h1A8001});
      chk("a_f3", fq0.pop_front(), {8'd24, 24'h1B0F0F});

      // Empty mask with inValid held: accept every other clk, no frame.
      @(negedge clk);
      en[0] = 4'h0;
      valid[0] = 1'b1;
      slow = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("a_empty_ready%0d", k), ready[0], (k % 2 == 1));
         chk($sformatf("a_empty_busy%0d", k), busy[0], (k % 2 == 0));
         if (!sync[0]) slow++;
      end
      valid[0] = 1'b0;
      chk("a_empty_no_sync", slow, 0);
      chk("a_empty_no_frame", fq0.size(), 0);

      // Reset at bit 10 of the second frame.
      repeat (2) @(negedge clk);
      send(0, {16'h0F0F, 16'h8001, 16'hABCD, 16'h1234}, 4'hF);
      nfall = 0;
      ps = sync[0];
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (ps && !sync[0]) nfall++;
         ps = sync[0];
         if (nfall == 2) break;
      end
      chk("a_second_frame_seen", nfall, 2);
      repeat (20) @(negedge clk);
      chk("a_mid_sync_low", sync[0], 0);
      resetN = 1'b0;
      #1;
      chk("a_mid_rst_sync", sync[0], 1);
      chk("a_mid_rst_sclk", sclk[0], 1);
      chk("a_mid_rst_din", din[0], 0);
      chk("a_mid_rst_busy", busy[0], 0);
      chk("a_mid_rst_fd", fd[0], 0);
      chk("a_mid_rst_ready", ready[0], 0);
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      fq0.delete();
      send(0, {16'h0000, 16'h0000, 16'hFF00, 16'h00FF}, 4'b0011);
      run_to_idle(0, nfd, nfall, low1, gap1, endok, tmo);
      chk("a_post_rst_timeout", tmo, 0);
      chk("a_post_rst_fd", nfd, 2);
      chk("a_post_rst_nframes", fq0.size(), 2);
      chk("a_post_rst_f0", fq0.pop_front(), {8'd24, 24'h1800FF});
      chk("a_post_rst_f1", fq0.pop_front(), {8'd24, 24'h19FF00});
      chk("a_din_only_sclk_high", viol0, 0);

      // Channels 1 and 3 with joint update.
      fq1.delete();
      send(1, {16'h0000, 12'hABC, 12'h000, 12'h123, 12'h000}, 4'b1010);
      run_to_idle(1, nfd, nfall, low1, gap1, endok, tmo);
      chk("b_mask_timeout", tmo, 0);
      chk("b_mask_fd", nfd, 2);
      chk("b_mask_sync_falls", nfall, 2);
      chk("b_mask_sync_low_clks", low1, 96);
      chk("b_mask_gap_clks", gap1, 4);
      chk("b_mask_end_ready_fd", endok, 1);
      chk("b_mask_nframes", fq1.size(), 2);
      chk("b_mask_f0", fq1.pop_front(), {8'd24, 24'h011230});
      chk("b_mask_f1", fq1.pop_front(), {8'd24, 24'h13ABC0});

      // Signed ch0: 0x800 maps to zero, and the sclk waveform is 1100.
      send(1, 64'(12'h800), 4'b0001);
      found = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (!sync[1]) begin found = 1'b1; break; end
         @(negedge clk);
      end
      chk("b_sign_sync_fall", found, 1);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("b_sclk_pat%0d", k), sclk[1], ((k % 4) < 2));
         @(negedge clk);
      end
      run_to_idle(1, nfd, nfall, low1, gap1, endok, tmo);
      chk("b_neg_timeout", tmo, 0);
      chk("b_neg_frame", fq1.pop_front(), {8'd24, 24'h100000});
      send(1, 64'(12'h7FF), 4'b0001);
      run_to_idle(1, nfd, nfall, low1, gap1, endok, tmo);
      chk("b_pos_timeout", tmo, 0);
      chk("b_pos_frame", fq1.pop_front(), {8'd24, 24'h10FFF0});
      chk("b_din_only_sclk_high", viol1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
